// File: rtl/param_stepper.sv
// Button-driven code stepper: tap steps once, hold auto-repeats after a delay,
// with saturating or wrapping range limits and a clamped parallel load.
module param_stepper #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned MIN_CODE      = 0,
  parameter int unsigned MAX_CODE      = 8,
  parameter int unsigned RESET_CODE    = 3,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned HOLD_DELAY    = 4,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] code,
  output logic             at_min,
  output logic             at_max,
  output logic             changed
);

  localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             dir_q, dir_d;
  logic             step_c;
  logic             btn_dir, btn_opp;
  logic [WIDTH-1:0] code_up, code_dn, load_clamped, code_d;

  assign cnt_inc = cnt_q + CW'(1);
  assign btn_dir = dir_q ? up : down;
  assign btn_opp = dir_q ? down : up;

  // Next-state / step decision; everything advances only on tick cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_c  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (up ^ down) begin
            step_c  = 1'b1;
            dir_d   = up;
            cnt_d   = '0;
            state_d = HOLD;
          end else if (up && down) begin
            state_d = WAIT_REL;
          end
        end
        HOLD, REPEAT: begin
          if (!btn_dir) begin
            state_d = IDLE;
          end else if (btn_opp) begin
            state_d = WAIT_REL;
          end else if (state_q == HOLD && cnt_inc == CW'(HOLD_DELAY)) begin
            step_c  = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else if (state_q == REPEAT && cnt_inc == CW'(REPEAT_PERIOD)) begin
            step_c  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_REL: begin
          if (!up && !down) state_d = IDLE;
        end
        default: state_d = WAIT_REL;
      endcase
    end
  end

  // Range-limited neighbours of the current code and the clamped load value
  always_comb begin
    if (code == WIDTH'(MAX_CODE)) code_up = (WRAP != 0) ? WIDTH'(MIN_CODE) : code;
    else                          code_up = code + WIDTH'(1);
    if (code == WIDTH'(MIN_CODE)) code_dn = (WRAP != 0) ? WIDTH'(MAX_CODE) : code;
    else                          code_dn = code - WIDTH'(1);
    if (int'(load_value) < int'(MIN_CODE))  load_clamped = WIDTH'(MIN_CODE);
    else if (load_value > WIDTH'(MAX_CODE)) load_clamped = WIDTH'(MAX_CODE);
    else                                    load_clamped = load_value;
  end

  // Load wins over a same-cycle step; the FSM still advances as if it stepped
  always_comb begin
    code_d = code;
    if (load)        code_d = load_clamped;
    else if (step_c) code_d = dir_d ? code_up : code_dn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_REL;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      code    <= WIDTH'(RESET_CODE);
      changed <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      code    <= code_d;
      changed <= (code_d != code);
    end
  end

  assign at_min = (code == WIDTH'(MIN_CODE));
  assign at_max = (code == WIDTH'(MAX_CODE));

endmodule

// File: doc/param_stepper.md
PARAM_STEPPER -- requirements
Module: param_stepper

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  WIDTH  4  bit width of code and load_value
  MIN_CODE  0  lowest legal code
  MAX_CODE  8  highest legal code
  RESET_CODE  3  code value after reset
  WRAP  0  0 = saturate at the range ends, 1 = wrap around
  HOLD_DELAY  4  ticks from a press until the first auto-repeat step (>=1)
  REPEAT_PERIOD  2  ticks between auto-repeat steps (>=1)
REQ-002 Parameter legality SHALL be MIN_CODE <= RESET_CODE <= MAX_CODE <= 2^WIDTH-1.
REQ-003 The ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock; all state changes on the rising edge
  rst  in  1  synchronous, active-high reset
  tick  in  1  one-cycle sample strobe; all button evaluation is gated by it
  up  in  1  debounced increment button, level
  down  in  1  debounced decrement button, level
  load  in  1  one-cycle load strobe; not gated by tick
  load_value  in  WIDTH  value to load
  code  out  WIDTH  current code, registered
  at_min  out  1  code == MIN_CODE
  at_max  out  1  code == MAX_CODE
  changed  out  1  one-cycle pulse when code changed in the previous cycle

Function
REQ-004 The FSM SHALL have four states: IDLE, HOLD, REPEAT, WAIT_REL. It SHALL hold a direction register dir and a tick counter sized to max(HOLD_DELAY, REPEAT_PERIOD).
REQ-005 The FSM SHALL change state and counter only on cycles with tick=1; on tick=0 cycles, state and counter SHALL hold.
REQ-006 IDLE rules:
  - Exactly one of up/down high: step once in that direction, latch dir, clear the counter, go to HOLD.
  - Both high: no step, go to WAIT_REL.
  - Neither high: stay in IDLE.
REQ-007 HOLD and REPEAT rules:
  - Button for dir low: go to IDLE with no step.
  - Opposite button high: go to WAIT_REL with no step.
  - Otherwise: increment the counter.
REQ-008 In HOLD, the step SHALL occur on the HOLD_DELAY-th tick after the press tick; the FSM then clears the counter and goes to REPEAT. In REPEAT, a step SHALL occur every REPEAT_PERIOD-th tick and the counter SHALL clear.
REQ-009 WAIT_REL SHALL go to IDLE on a tick with up=0 and down=0, and SHALL never step.
REQ-010 A step SHALL update code on the same clock edge as the deciding tick cycle (1-cycle latency from the sampled inputs).
REQ-011 Boundary behaviour:
  - WRAP=0: a step beyond MAX_CODE or below MIN_CODE SHALL leave code unchanged with no changed pulse; the FSM proceeds normally.
  - WRAP=1: up from MAX_CODE SHALL give MIN_CODE, and down from MIN_CODE SHALL give MAX_CODE.
REQ-012 load=1 SHALL set code to load_value clamped to [MIN_CODE, MAX_CODE] on any cycle.
REQ-013 load SHALL take priority over a same-cycle step, which is discarded. The FSM state and counter SHALL still advance as if the step had happened.
REQ-014 changed SHALL be registered: high for exactly the cycle after any edge where code's value differed from its prior value, whether by step or load.
REQ-015 at_min and at_max SHALL be combinational decodes of registered code.

Reset
REQ-016 Reset values when rst=1 at a clock edge: code=RESET_CODE, state=WAIT_REL, counter=0, dir=up, changed=0.
REQ-017 rst SHALL take priority over load, tick and the buttons.
REQ-018 Reset in mid-HOLD or mid-REPEAT SHALL abort the repeat. A button still held after reset SHALL cause no step until released.

Verification (defaults unless stated; tick every 4th cycle; t0 = first tick with the button high)
REQ-019 Reset: assert rst for 2 cycles with up=1 held -> code=3, at_min=0, at_max=0, changed=0; no step until up is released and pressed again.
REQ-020 Tap: up high for exactly tick t0 -> code 3->4 after t0; changed high 1 cycle; then no further change.
REQ-021 Hold: up high for ticks t0..t12 from code 3 -> steps at t0(4), t4(5), t6(6), t8(7), t10(8); at t12 code stays 8, at_max=1, no changed pulse.
REQ-022 Conflict: up and down both high at t0, then down only from t3 -> code unchanged until both are released; a fresh down press then gives 3->2.
REQ-023 Wrap: WRAP=1, code=8, tap up -> code=0, at_min=1; tap down -> code=8.
REQ-024 Load priority: load=1 with load_value=12 on the same cycle as tick+up at code 3 -> code=8 (clamped), not 4; changed high 1 cycle.
